// File: rtl/nrisc_pkg.sv
// Shared types and constants for the nRISC instruction-fetch stage.
// Memory read latency is fixed by the program memory, not configurable per instance.
package nrisc_pkg;

  localparam int TAM     = 16;
  localparam int IW      = 16;
  localparam int MEM_LAT = 2;

  typedef struct packed {
    logic [IW-1:0]  instr;
    logic [TAM-1:0] pc;
  } fetch_entry_t;

  function automatic logic [TAM-1:0] pc_inc(input logic [TAM-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/nrisc_fetch_if.sv
// Fetch-stage bus: program-memory address/data plus the decode handshake and redirect.
// The master side is the fetch stage; the slave side is memory + decode.
interface nrisc_fetch_if #(
  parameter int TAM = nrisc_pkg::TAM,
  parameter int IW  = nrisc_pkg::IW
);

  logic [TAM-1:0] progADDR;
  logic [IW-1:0]  Instruction;
  logic [IW-1:0]  InstrOut;
  logic [TAM-1:0] InstrPC;
  logic           InstrValid;
  logic           InstrReady;
  logic           Redirect;
  logic [TAM-1:0] RedirectADDR;

  modport master (
    output progADDR, InstrOut, InstrPC, InstrValid,
    input  Instruction, InstrReady, Redirect, RedirectADDR
  );

  modport slave (
    input  progADDR, InstrOut, InstrPC, InstrValid,
    output Instruction, InstrReady, Redirect, RedirectADDR
  );

endinterface

// File: rtl/nrisc_fetch_fifo.sv
// Show-ahead circular FIFO of fetched {instr, pc} entries with synchronous flush.
// The head entry reads as all-zero while the FIFO is empty.
module nrisc_fetch_fifo
  import nrisc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW:0]   count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == DEPTH_C);
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  assign do_push = push && !full;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: stale slots are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/nrisc_fetch.sv
// Instruction-fetch stage: owns the PC, tracks the fixed-latency memory pipeline
// and buffers returned instructions for decode. TAM/IW must match nrisc_pkg.
module nrisc_fetch #(
  parameter int             TAM     = nrisc_pkg::TAM,
  parameter int             IW      = nrisc_pkg::IW,
  parameter int             DEPTH   = 4,
  parameter logic [TAM-1:0] RST_VEC = '0
) (
  input  logic          clk,
  input  logic          rst,
  nrisc_fetch_if.master bus
);

  import nrisc_pkg::fetch_entry_t;
  import nrisc_pkg::MEM_LAT;
  import nrisc_pkg::pc_inc;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [TAM-1:0]     pc_reg;
  logic [MEM_LAT-1:0] vld;
  logic [TAM-1:0]     tag [MEM_LAT];
  logic [CW:0]        occ;
  logic               issue;

  logic [CW-1:0]      fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic [IW-1:0]      instr_in;
  fetch_entry_t       entry_in;
  fetch_entry_t       entry_out;

  // Credit rule: buffered plus in-flight reads never exceed the buffer size,
  // so every read that returns is guaranteed a slot.
  always_comb begin
    occ = {1'b0, fifo_count};
    for (int i = 0; i < MEM_LAT; i++) begin
      occ = occ + {{CW{1'b0}}, vld[i]};
    end
  end

  assign issue = !bus.Redirect && (occ < DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RST_VEC;
    end else if (bus.Redirect) begin
      pc_reg <= bus.RedirectADDR;
    end else if (issue) begin
      pc_reg <= pc_inc(pc_reg);
    end
  end

  assign bus.progADDR = pc_reg;

  // One stage per memory-latency cycle; the last stage lines up with Instruction.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_LAT; gi++) begin : g_stage
      logic           v_reg;
      logic [TAM-1:0] t_reg;

      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst || bus.Redirect) begin
            v_reg <= 1'b0;
            t_reg <= '0;
          end else begin
            v_reg <= issue;
            if (issue) t_reg <= pc_reg;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (rst || bus.Redirect) begin
            v_reg <= 1'b0;
            t_reg <= '0;
          end else begin
            v_reg <= vld[gi-1];
            t_reg <= tag[gi-1];
          end
        end
      end

      assign vld[gi] = v_reg;
      assign tag[gi] = t_reg;
    end
  endgenerate

  assign instr_in  = bus.Instruction;
  assign entry_in  = '{instr: instr_in, pc: tag[MEM_LAT-1]};
  assign fifo_push = vld[MEM_LAT-1];
  assign fifo_pop  = bus.InstrValid && bus.InstrReady;

  nrisc_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.Redirect),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (entry_in),
    .dout  (entry_out),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.InstrValid = !fifo_empty;
  assign bus.InstrOut   = entry_out.instr;
  assign bus.InstrPC    = entry_out.pc;

  always_ff @(posedge clk) begin
    if (!rst && !bus.Redirect) begin
      assert (!(fifo_push && fifo_full));
    end
  end

endmodule
